// File: rtl/fminmax_pkg.sv
// Shared types and helpers for the fminmax_reduce IEEE-754 min/max reduction block.
package fminmax_pkg;

    localparam int unsigned FP_MAX_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only; caller truncates to its width.
    function automatic logic [FP_MAX_W-1:0] canon_qnan(input int unsigned exp_w,
                                                       input int unsigned man_w);
        logic [FP_MAX_W-1:0] q;
        q = '0;
        for (int unsigned i = 0; i < FP_MAX_W; i++) begin
            if ((i >= man_w - 1) && (i < man_w + exp_w)) begin
                q[i] = 1'b1;
            end
        end
        return q;
    endfunction

endpackage

// File: rtl/fminmax_cmp.sv
// Combinational IEEE-754 min/max of two operands using sign-magnitude ordering (no adder).
module fminmax_cmp
    import fminmax_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         is_max,
    output logic [W-1:0] result,
    output logic         a_snan,
    output logic         b_snan
);

    localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));

    logic           a_sign;
    logic           b_sign;
    logic [W-2:0]   a_mag;
    logic [W-2:0]   b_mag;
    logic           a_nan;
    logic           b_nan;
    logic           a_gt_b;
    logic           b_gt_a;
    logic           pick_b;

    assign a_sign = a[W-1];
    assign b_sign = b[W-1];
    assign a_mag  = a[W-2:0];
    assign b_mag  = b[W-2:0];
    assign a_nan  = (&a[W-2:MAN_W]) && (|a[MAN_W-1:0]);
    assign b_nan  = (&b[W-2:MAN_W]) && (|b[MAN_W-1:0]);
    assign a_snan = a_nan && !a[MAN_W-1];
    assign b_snan = b_nan && !b[MAN_W-1];

    // Opposite signs: the positive one is greater, which also puts -0 below +0.
    always_comb begin
        a_gt_b = 1'b0;
        b_gt_a = 1'b0;
        if (a_sign != b_sign) begin
            a_gt_b = !a_sign;
            b_gt_a = a_sign;
        end else if (!a_sign) begin
            a_gt_b = a_mag > b_mag;
            b_gt_a = b_mag > a_mag;
        end else begin
            a_gt_b = a_mag < b_mag;
            b_gt_a = b_mag < a_mag;
        end
    end

    always_comb begin
        pick_b = is_max ? b_gt_a : a_gt_b;
        result = pick_b ? b : a;
        if (a_nan && b_nan) begin
            result = QNAN;
        end else if (a_nan) begin
            result = b;
        end else if (b_nan) begin
            result = a;
        end
    end

endmodule

// File: rtl/fminmax_reduce.sv
// Streaming min/max reduction over a vector of IEEE-754 elements.
// Define FMINMAX_INVALID_EN to add the sticky out_invalid (signalling NaN seen) flag.
module fminmax_reduce
    import fminmax_pkg::*;
#(
    parameter  int unsigned EXP_W = 8,
    parameter  int unsigned MAN_W = 23,
    localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic         in_max,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
`ifdef FMINMAX_INVALID_EN
    ,
    output logic         out_invalid
`endif
);

    localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));

    state_e        state;
    state_e        state_nxt;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_nxt;
    logic          mode;
    logic          mode_nxt;
    logic          valid_nxt;
    logic          ready_nxt;
    logic          accept;
    logic          in_nan;
    logic [W-1:0]  cmp_res;
    logic          a_snan;
    logic          b_snan;

    assign accept   = in_valid && in_ready;
    assign in_nan   = (&in_data[W-2:MAN_W]) && (|in_data[MAN_W-1:0]);
    assign out_data = acc;

    fminmax_cmp #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_cmp (
        .a      (acc),
        .b      (in_data),
        .is_max (mode),
        .result (cmp_res),
        .a_snan (a_snan),
        .b_snan (b_snan)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A lone NaN first element is canonicalised so a NaN-only vector yields the canonical qNaN.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        mode_nxt  = mode;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_nxt   = in_nan ? QNAN : in_data;
                    mode_nxt  = in_max;
                    state_nxt = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_nxt = cmp_res;
                    if (in_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        valid_nxt = (state_nxt == DONE);
        ready_nxt = (state_nxt != DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc       <= '0;
            mode      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            acc       <= acc_nxt;
            mode      <= mode_nxt;
            out_valid <= valid_nxt;
            in_ready  <= ready_nxt;
        end
    end

`ifdef FMINMAX_INVALID_EN
    logic invalid_nxt;

    // Sticky across the vector; restarts with the first element and clears on result handoff.
    always_comb begin
        invalid_nxt = out_invalid;
        case (state)
            IDLE: begin
                if (accept) begin
                    invalid_nxt = b_snan;
                end
            end
            ACC: begin
                if (accept) begin
                    invalid_nxt = out_invalid || a_snan || b_snan;
                end
            end
            DONE: begin
                if (out_ready) begin
                    invalid_nxt = 1'b0;
                end
            end
            default: begin
                invalid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_invalid <= 1'b0;
        end else begin
            out_invalid <= invalid_nxt;
        end
    end
`else
    logic snan_unused;
    assign snan_unused = a_snan | b_snan;
`endif

endmodule

// File: tb/tb_fminmax_reduce.sv
// Directed scoreboard bench for fminmax_reduce (binary32 and binary64 instances).
module tb_fminmax_reduce;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] in_data   = '0;
    logic        in_last   = 1'b0;
    logic        in_max    = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    logic        d_in_valid  = 1'b0;
    logic        d_in_ready;
    logic [63:0] d_in_data   = '0;
    logic        d_in_last   = 1'b0;
    logic        d_in_max    = 1'b0;
    logic        d_out_valid;
    logic        d_out_ready = 1'b0;
    logic [63:0] d_out_data;

`ifdef FMINMAX_INVALID_EN
    logic        out_invalid;
    logic        d_out_invalid;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic        inv_q[$];

    always #5 CLK = ~CLK;

    fminmax_reduce #(.EXP_W(8), .MAN_W(23)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_max    (in_max),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FMINMAX_INVALID_EN
        ,
        .out_invalid (out_invalid)
`endif
    );

    fminmax_reduce #(.EXP_W(11), .MAN_W(52)) dut64 (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (d_in_valid),
        .in_ready  (d_in_ready),
        .in_data   (d_in_data),
        .in_last   (d_in_last),
        .in_max    (d_in_max),
        .out_valid (d_out_valid),
        .out_ready (d_out_ready),
        .out_data  (d_out_data)
`ifdef FMINMAX_INVALID_EN
        ,
        .out_invalid (d_out_invalid)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the element is accepted.
    task automatic send(input logic [31:0] d, input logic last, input logic mx);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_max   = mx;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 20) chk("send_ready", 64'(in_ready), 64'd1);
        @(negedge CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (last) chk("latency_valid", 64'(out_valid), 64'd1);
    endtask

    task automatic expect_vec(input logic [31:0] r, input logic inv);
        exp_q.push_back(r);
        inv_q.push_back(inv);
    endtask

    task automatic collect(input string tag);
        int          n;
        logic [31:0] e;
        logic        ei;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        e  = exp_q.pop_front();
        ei = inv_q.pop_front();
        chk({tag, "_data"}, 64'(out_data), 64'(e));
`ifdef FMINMAX_INVALID_EN
        chk({tag, "_invalid"}, 64'(out_invalid), 64'(ei));
`else
        if (ei) n = 0;
`endif
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        chk({tag, "_released"}, 64'(out_valid), 64'd0);
        chk({tag, "_ready_again"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("idle_ready", 64'(in_ready), 64'd1);

        // max of 1, 2, -3
        expect_vec(32'h4000_0000, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b1);
        send(32'h4000_0000, 1'b0, 1'b0);
        send(32'hC040_0000, 1'b1, 1'b0);
        collect("max3");

        // signed zeros, both orders
        expect_vec(32'h8000_0000, 1'b0);
        send(32'h0000_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 1'b1, 1'b0);
        collect("min_pz_nz");
        expect_vec(32'h0000_0000, 1'b0);
        send(32'h0000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 1'b1, 1'b1);
        collect("max_pz_nz");
        expect_vec(32'h8000_0000, 1'b0);
        send(32'h8000_0000, 1'b0, 1'b0);
        send(32'h0000_0000, 1'b1, 1'b0);
        collect("min_nz_pz");
        expect_vec(32'h0000_0000, 1'b0);
        send(32'h8000_0000, 1'b0, 1'b1);
        send(32'h0000_0000, 1'b1, 1'b1);
        collect("max_nz_pz");

        // NaN handling
        expect_vec(32'h3F80_0000, 1'b0);
        send(32'h7FC0_0000, 1'b0, 1'b1);
        send(32'h3F80_0000, 1'b1, 1'b1);
        collect("max_qnan_one");
        expect_vec(32'h7FC0_0000, 1'b1);
        send(32'h7F80_0001, 1'b0, 1'b1);
        send(32'h7FC0_0000, 1'b1, 1'b1);
        collect("max_snan_qnan");
        expect_vec(32'h3F80_0000, 1'b1);
        send(32'h3F80_0000, 1'b0, 1'b1);
        send(32'h7F80_0001, 1'b1, 1'b1);
        collect("max_one_snan");
        expect_vec(32'h7FC0_0000, 1'b0);
        send(32'h7FFF_FFFF, 1'b1, 1'b0);
        collect("single_nan");

        // negative magnitudes, infinities, in_max ignored after first element
        expect_vec(32'hC000_0000, 1'b0);
        send(32'hC000_0000, 1'b0, 1'b0);
        send(32'hBF80_0000, 1'b1, 1'b0);
        collect("min_neg");
        expect_vec(32'h7F80_0000, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b1);
        send(32'h7F80_0000, 1'b1, 1'b1);
        collect("max_pinf");
        expect_vec(32'hC040_0000, 1'b0);
        send(32'h3F80_0000, 1'b0, 1'b0);
        send(32'h4000_0000, 1'b0, 1'b1);
        send(32'hC040_0000, 1'b1, 1'b1);
        collect("mode_latched");

        // single -inf min with output backpressure
        expect_vec(32'hFF80_0000, 1'b0);
        send(32'hFF80_0000, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'hFF80_0000);
            chk("hold_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        collect("single_ninf");

        // reset mid-vector discards the partial result
        send(32'h4100_0000, 1'b0, 1'b1);
        send(32'h4200_0000, 1'b0, 1'b1);
        RST = 1'b1;
        #1;
        chk("midrst_data", 64'(out_data), 64'd0);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_rst_valid", 64'(out_valid), 64'd0);
        end
        expect_vec(32'h4040_0000, 1'b0);
        send(32'h4040_0000, 1'b1, 1'b1);
        collect("after_rst");

        // binary64 instance
        d_in_valid = 1'b1;
        d_in_data  = 64'hBFF0_0000_0000_0000;
        d_in_max   = 1'b1;
        d_in_last  = 1'b0;
        chk("d_ready", 64'(d_in_ready), 64'd1);
        @(negedge CLK);
        d_in_data  = 64'h3FF0_0000_0000_0000;
        d_in_last  = 1'b1;
        @(negedge CLK);
        d_in_valid = 1'b0;
        d_in_last  = 1'b0;
        chk("d_valid", 64'(d_out_valid), 64'd1);
        chk("d_data", d_out_data, 64'h3FF0_0000_0000_0000);
        d_out_ready = 1'b1;
        @(negedge CLK);
        d_out_ready = 1'b0;
        chk("d_released", 64'(d_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fminmax_reduce.md
FMINMAX_REDUCE -- requirements
Module: fminmax_reduce

Interface
REQ-001 Parameter EXP_W, default 8, exponent width; 11 selects binary64.
REQ-002 Parameter MAN_W, default 23, fraction width; 52 selects binary64.
REQ-003 Localparam W = 1+EXP_W+MAN_W shall be the operand width.
REQ-004 CLK  input  1  clock, all state on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  element offered.
REQ-007 in_ready  output  1  element accepted when in_valid&&in_ready.
REQ-008 in_data  input  W  IEEE-754 element.
REQ-009 in_last  input  1  final element of current vector.
REQ-010 in_max  input  1  1=max, 0=min; sampled with first element of a vector only.
REQ-011 out_valid  output  1  result held.
REQ-012 out_ready  input  1  result consumed when out_valid&&out_ready.
REQ-013 out_data  output  W  reduced result.
REQ-014 out_invalid  output  1  any sNaN seen in the vector (present only with FMINMAX_INVALID_EN).

Function
REQ-015 States IDLE (no element yet), ACC (accumulating), DONE (result held); reset to IDLE.
REQ-016 IDLE: accepted element loads accumulator with element, latches in_max; -> DONE if in_last, else -> ACC.
REQ-017 ACC: accepted element replaces accumulator with compare(acc, element); -> DONE if in_last.
REQ-018 DONE: out_valid=1, in_ready=0; on out_ready -> IDLE (no element accepted in that same cycle).
REQ-019 in_ready shall be 1 in IDLE and ACC, 0 in DONE; throughput one element per cycle.
REQ-020 Latency: out_valid asserts the cycle after the in_last element is accepted.
REQ-021 Comparison shall be sign-magnitude ordering, no adder: opposite signs -> positive greater; both positive -> larger {exp,frac} greater; both negative -> smaller {exp,frac} greater.
REQ-022 -0 shall order below +0: max(-0,+0)=+0, min(-0,+0)=-0, for either operand order.
REQ-023 One NaN operand: result is the other operand; both NaN: canonical qNaN {0, all-ones exp, 1, zeros}.
REQ-024 Single-element vector whose element is NaN: result canonical qNaN.
REQ-025 Infinities shall follow ordinary ordering (+inf max, -inf min).
REQ-026 out_data stable while out_valid&&!out_ready.
REQ-027 in_max changes after the first element shall be ignored until the next vector.

Reset
REQ-028 RST asserted shall immediately force state IDLE, out_valid=0, out_data=0, out_invalid=0, accumulator=0, latched mode=0.
REQ-029 RST mid-vector or in DONE shall discard partial result; no result emitted.

Configuration
REQ-030 Macro FMINMAX_INVALID_EN defined: out_invalid port exists; sticky flag set on any accepted sNaN (exp all-ones, frac nonzero, frac MSB 0), cleared on entry to IDLE; valid with out_data.
REQ-031 FMINMAX_INVALID_EN undefined: port and flag logic absent; all other behaviour identical.

Structure
REQ-032 Package fminmax_pkg shall hold state enum (IDLE/ACC/DONE) and canonical-qNaN function parametrised by EXP_W/MAN_W.
REQ-033 Sub-module fminmax_cmp (combinational: a, b, is_max -> result, a_snan, b_snan) shall hold REQ-021..REQ-025 logic.

Verification
REQ-034 max of {0x3F800000, 0x40000000, 0xC0400000}, last on 3rd -> out_data 0x40000000 cycle after 3rd accept.
REQ-035 min of {0x00000000, 0x80000000} -> 0x80000000; max same -> 0x00000000; repeat swapped order, same results.
REQ-036 max of {0x7FC00000, 0x3F800000} -> 0x3F800000; max of {0x7F800001, 0x7FC00000} -> 0x7FC00000, out_invalid=1 (with macro).
REQ-037 Single element 0xFF800000 min, in_last=1 -> 0xFF800000; out_ready held 0 for 5 cycles -> out_valid, out_data stable, in_ready=0.
REQ-038 RST pulsed after 2 of 4 elements -> out_valid stays 0; next vector {0x40400000} max -> 0x40400000.
REQ-039 EXP_W=11, MAN_W=52: max of {0xBFF0000000000000, 0x3FF0000000000000} -> 0x3FF0000000000000.
